// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM state type and timeout default for the MEM stage controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 32;
  localparam int RADDR_W_DEF     = 3;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Timeout counter width: wide enough for the limit, never narrower than 8 bits.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
// Latency: n/a (wires only).
// Backpressure: master holds req/we/addr/wdata stable until ack.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB writeback register: one-cycle write strobe plus held address/data.
// Latency: 1 cycle from ld to wb_wen.
// Backpressure: none; the register file always accepts.
module mem_wb_reg #(
  parameter int RADDR_W = 3,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld,
  input  logic [RADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               wb_wen,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data
);

  // Strobe follows ld each cycle; address/data only move when a result is loaded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_wen  <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_wen <= ld;
      if (ld) begin
        wb_addr <= ld_addr;
        wb_data <= ld_data;
      end
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: ALU results pass to writeback, loads/stores run a req/ack memory transaction.
// Latency: ALU 1 cycle to wb_wen; memory op >= 2 cycles (capture cycle + ack cycle).
// Backpressure: stall_out holds EX/MEM while a memory op is outstanding. Optional MEM_TIMEOUT_EN aborts a hung access.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RADDR_W     = RADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid_in,
  input  logic               load_in,
  input  logic               store_in,
  input  logic [ADDR_W-1:0]  mem_addr_in,
  input  logic [RADDR_W-1:0] rdest_addr_in,
  input  logic [DATA_W-1:0]  rdest_data_in,
  output logic               stall_out,
  mem_stage_ctrl_if.master   dmem,
  output logic               wb_wen,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               mem_err
);

  state_t             state_q, state_d;
  logic               mem_op;
  logic               stall;
  logic               timeout_hit;
  logic [ADDR_W-1:0]  lat_addr;
  logic               lat_we;
  logic [DATA_W-1:0]  lat_wdata;
  logic [RADDR_W-1:0] lat_rdest;
  logic               wb_ld;
  logic [RADDR_W-1:0] wb_ld_addr;
  logic [DATA_W-1:0]  wb_ld_data;

  assign mem_op = valid_in & (load_in | store_in);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  // Ack-wait counter: cleared outside ACCESS, counts ACCESS cycles without ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (state_q != ACCESS) begin
      to_cnt <= '0;
    end else if (!dmem.dmem_ack) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Limit is reached at the edge closing this cycle; a coincident ack takes precedence.
  assign timeout_hit = (state_q == ACCESS) && !dmem.dmem_ack &&
                       (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end

  assign mem_err = err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Capture the memory op on the IDLE edge that launches it; store wins over load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_rdest <= '0;
    end else if (state_q == IDLE && mem_op) begin
      lat_addr  <= mem_addr_in;
      lat_we    <= store_in;
      lat_wdata <= rdest_data_in;
      lat_rdest <= rdest_addr_in;
    end
  end

  // Next state, stall and writeback selection.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    wb_ld      = 1'b0;
    wb_ld_addr = rdest_addr_in;
    wb_ld_data = rdest_data_in;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          state_d = ACCESS;
        end else if (valid_in) begin
          wb_ld = 1'b1;
        end
      end
      ACCESS: begin
        wb_ld_addr = lat_rdest;
        if (dmem.dmem_ack) begin
          state_d    = IDLE;
          wb_ld      = !lat_we;
          wb_ld_data = dmem.dmem_rdata;
        end else if (timeout_hit) begin
          // Aborted load still retires, with zero data.
          state_d    = IDLE;
          wb_ld      = !lat_we;
          wb_ld_data = '0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is forced low during reset even if EX/MEM still presents an op.
  assign stall_out = resetn & stall;

  assign dmem.dmem_req   = (state_q == ACCESS);
  assign dmem.dmem_we    = (state_q == ACCESS) & lat_we;
  assign dmem.dmem_addr  = (state_q == ACCESS) ? lat_addr  : '0;
  assign dmem.dmem_wdata = (state_q == ACCESS) ? lat_wdata : '0;

  mem_wb_reg #(
    .RADDR_W (RADDR_W),
    .DATA_W  (DATA_W)
  ) u_wb_reg (
    .clk     (clk),
    .resetn  (resetn),
    .ld      (wb_ld),
    .ld_addr (wb_ld_addr),
    .ld_data (wb_ld_data),
    .wb_wen  (wb_wen),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed and random instruction streams against a transaction-level model.
// Latency: n/a.
// Backpressure: bench holds EX/MEM inputs while stall_out is expected high.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_in, load_in, store_in;
  logic [15:0] mem_addr_in;
  logic [2:0]  rdest_addr_in;
  logic [31:0] rdest_data_in;
  logic        stall_out;
  logic        wb_wen;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: last architecturally visible writeback pair.
  logic [2:0]  exp_addr;
  logic [31:0] exp_data;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.ADDR_W(16), .DATA_W(32)) dmem_if ();

  mem_stage_ctrl #(
    .ADDR_W      (16),
    .DATA_W      (32),
    .RADDR_W     (3),
    .TIMEOUT_CYC (TB_TO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .valid_in      (valid_in),
    .load_in       (load_in),
    .store_in      (store_in),
    .mem_addr_in   (mem_addr_in),
    .rdest_addr_in (rdest_addr_in),
    .rdest_data_in (rdest_data_in),
    .stall_out     (stall_out),
    .dmem          (dmem_if.master),
    .wb_wen        (wb_wen),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .mem_err       (mem_err)
  );

  // One instruction: ALU/idle retires in 1 cycle; a memory op stalls for
  // the capture cycle plus (delay+1) ACCESS cycles minus the ack cycle.
  task automatic run_op(input logic v, input logic ld, input logic st,
                        input logic [15:0] a, input logic [2:0] rd, input logic [31:0] d,
                        input int delay, input logic [31:0] rdata, input logic spurious);
    logic is_mem, is_wr, last;
    is_mem = v & (ld | st);
    is_wr  = st;
    @(negedge clk);
    valid_in = v; load_in = ld; store_in = st;
    mem_addr_in = a; rdest_addr_in = rd; rdest_data_in = d;
    dmem_if.dmem_ack   = spurious;
    dmem_if.dmem_rdata = $urandom;
    #1;
    tests_run++; if (stall_out !== is_mem) begin tests_failed++; $display("FAIL stall_present: got %b want %b", stall_out, is_mem); end
    tests_run++; if (dmem_if.dmem_req !== 1'b0) begin tests_failed++; $display("FAIL req_in_idle: got %b want 0", dmem_if.dmem_req); end
    @(posedge clk); #1;
    if (!is_mem) begin
      if (v) begin exp_addr = rd; exp_data = d; end
      tests_run++; if (wb_wen !== v) begin tests_failed++; $display("FAIL alu_wen: got %b want %b", wb_wen, v); end
      tests_run++; if (wb_addr !== exp_addr) begin tests_failed++; $display("FAIL alu_addr: got %h want %h", wb_addr, exp_addr); end
      tests_run++; if (wb_data !== exp_data) begin tests_failed++; $display("FAIL alu_data: got %h want %h", wb_data, exp_data); end
    end else begin
      tests_run++; if (wb_wen !== 1'b0) begin tests_failed++; $display("FAIL capture_wen: got %b want 0", wb_wen); end
      for (int k = 0; k <= delay; k++) begin
        last = (k == delay);
        @(negedge clk);
        dmem_if.dmem_ack   = last;
        dmem_if.dmem_rdata = rdata;
        #1;
        tests_run++; if (dmem_if.dmem_req !== 1'b1) begin tests_failed++; $display("FAIL access_req: got %b want 1", dmem_if.dmem_req); end
        tests_run++; if (dmem_if.dmem_we !== is_wr) begin tests_failed++; $display("FAIL access_we: got %b want %b", dmem_if.dmem_we, is_wr); end
        tests_run++; if (dmem_if.dmem_addr !== a) begin tests_failed++; $display("FAIL access_addr: got %h want %h", dmem_if.dmem_addr, a); end
        if (is_wr) begin
          tests_run++; if (dmem_if.dmem_wdata !== d) begin tests_failed++; $display("FAIL access_wdata: got %h want %h", dmem_if.dmem_wdata, d); end
        end
        tests_run++; if (stall_out !== !last) begin tests_failed++; $display("FAIL access_stall: got %b want %b", stall_out, !last); end
        @(posedge clk); #1;
        if (last && !is_wr) begin exp_addr = rd; exp_data = rdata; end
        tests_run++; if (wb_wen !== (last && !is_wr)) begin tests_failed++; $display("FAIL mem_wen: got %b want %b", wb_wen, last && !is_wr); end
        tests_run++; if (wb_addr !== exp_addr) begin tests_failed++; $display("FAIL mem_wb_addr: got %h want %h", wb_addr, exp_addr); end
        tests_run++; if (wb_data !== exp_data) begin tests_failed++; $display("FAIL mem_wb_data: got %h want %h", wb_data, exp_data); end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    valid_in = 0; load_in = 0; store_in = 0;
    mem_addr_in = '0; rdest_addr_in = '0; rdest_data_in = '0;
    dmem_if.dmem_ack = 0; dmem_if.dmem_rdata = '0;
    exp_addr = '0; exp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (stall_out !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    tests_run++; if (dmem_if.dmem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", dmem_if.dmem_req); end
    tests_run++; if (dmem_if.dmem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", dmem_if.dmem_we); end
    tests_run++; if (wb_wen !== 1'b0) begin tests_failed++; $display("FAIL reset_wen: got %b want 0", wb_wen); end
    tests_run++; if (wb_addr !== 3'd0) begin tests_failed++; $display("FAIL reset_wb_addr: got %h want 0", wb_addr); end
    tests_run++; if (wb_data !== 32'd0) begin tests_failed++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    tests_run++; if (mem_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", mem_err); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_alu_pass();
    run_op(1, 0, 0, 16'h1234, 3'd5, 32'hDEADBEEF, 0, 32'h0, 0);
    run_op(0, 0, 0, 16'h0, 3'd1, 32'h11111111, 0, 32'h0, 0);
  endtask

  task automatic test_load_wait();
    run_op(1, 1, 0, 16'h0040, 3'd2, 32'h0BADF00D, 3, 32'h12345678, 0);
  endtask

  task automatic test_store_same_cycle();
    run_op(1, 0, 1, 16'h0010, 3'd4, 32'hCAFEF00D, 0, 32'hFFFFFFFF, 0);
  endtask

  task automatic test_back_to_back();
    run_op(1, 1, 0, 16'h0100, 3'd3, 32'h0, 1, 32'hA5A5A5A5, 1);
    run_op(1, 0, 1, 16'h0104, 3'd7, 32'h5A5A5A5A, 0, 32'h0, 1);
    run_op(1, 1, 1, 16'h0108, 3'd0, 32'h77777777, 2, 32'h99999999, 0);
    run_op(1, 1, 0, 16'h010C, 3'd0, 32'h0, 0, 32'h13579BDF, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
             16'($urandom), 3'($urandom), $urandom,
             $urandom_range(0, 3), $urandom, 1'($urandom));
    end
    tests_run++; if (mem_err !== 1'b0) begin tests_failed++; $display("FAIL random_err: got %b want 0", mem_err); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid_in = 1; load_in = 1; store_in = 0;
    mem_addr_in = 16'h0200; rdest_addr_in = 3'd6; rdest_data_in = 32'h0;
    dmem_if.dmem_ack = 0;
    @(negedge clk); #1;
    tests_run++; if (dmem_if.dmem_req !== 1'b1) begin tests_failed++; $display("FAIL midrst_req_before: got %b want 1", dmem_if.dmem_req); end
    resetn = 1'b0;
    #1;
    tests_run++; if (dmem_if.dmem_req !== 1'b0) begin tests_failed++; $display("FAIL midrst_req: got %b want 0", dmem_if.dmem_req); end
    tests_run++; if (stall_out !== 1'b0) begin tests_failed++; $display("FAIL midrst_stall: got %b want 0", stall_out); end
    tests_run++; if (wb_wen !== 1'b0) begin tests_failed++; $display("FAIL midrst_wen: got %b want 0", wb_wen); end
    valid_in = 0; load_in = 0;
    exp_addr = '0; exp_data = '0;
    @(negedge clk);
    resetn = 1'b1;
    dmem_if.dmem_ack = 1;
    run_op(0, 0, 0, 16'h0, 3'd0, 32'h0, 0, 32'h0, 1);
    run_op(0, 0, 0, 16'h0, 3'd0, 32'h0, 0, 32'h0, 0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    valid_in = 1; load_in = 1; store_in = 0;
    mem_addr_in = 16'h0077; rdest_addr_in = 3'd6; rdest_data_in = 32'h0;
    dmem_if.dmem_ack = 0;
    @(posedge clk);
    for (int k = 1; k <= TB_TO; k++) begin
      @(negedge clk); #1;
      tests_run++; if (dmem_if.dmem_req !== 1'b1) begin tests_failed++; $display("FAIL to_req: got %b want 1", dmem_if.dmem_req); end
      tests_run++; if (stall_out !== (k != TB_TO)) begin tests_failed++; $display("FAIL to_stall: got %b want %b", stall_out, k != TB_TO); end
      @(posedge clk); #1;
      tests_run++; if (wb_wen !== (k == TB_TO)) begin tests_failed++; $display("FAIL to_wen: got %b want %b", wb_wen, k == TB_TO); end
      tests_run++; if (mem_err !== (k == TB_TO)) begin tests_failed++; $display("FAIL to_err: got %b want %b", mem_err, k == TB_TO); end
    end
    tests_run++; if (wb_data !== 32'd0) begin tests_failed++; $display("FAIL to_wb_data: got %h want 0", wb_data); end
    tests_run++; if (wb_addr !== 3'd6) begin tests_failed++; $display("FAIL to_wb_addr: got %h want 6", wb_addr); end
    tests_run++; if (dmem_if.dmem_req !== 1'b0) begin tests_failed++; $display("FAIL to_req_drop: got %b want 0", dmem_if.dmem_req); end
    exp_addr = 3'd6; exp_data = 32'd0;
    run_op(1, 0, 0, 16'h0, 3'd1, 32'h00C0FFEE, 0, 32'h0, 0);
    tests_run++; if (mem_err !== 1'b1) begin tests_failed++; $display("FAIL to_err_sticky: got %b want 1", mem_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_pass();
    test_load_wait();
    test_store_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
